// File: rtl/seq_pkg.sv
// Shared definitions for both ends of the 10110 serial link.
// Transmitter and detector import these so that they agree on the frame.
package seq_pkg;

  localparam int                    SEQ_PAT_W   = 5;
  localparam logic [SEQ_PAT_W-1:0]  SEQ_PATTERN = 5'b10110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/seq_10110_tx_if.sv
// Handshake and serial-output bundle of the 10110 transmitter.
// The master drives burst requests; the slave is the transmitter.
interface seq_10110_tx_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);

  logic             start;
  logic [CNT_W-1:0] rep_count;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, rep_count, gap, abort,
    input  dout, dout_valid, busy, done, frames_sent
  );

  modport slave (
    input  start, rep_count, gap, abort,
    output dout, dout_valid, busy, done, frames_sent
  );

endinterface

// File: rtl/down_counter.sv
// Loadable unsigned down-counter that stops at zero.
// It exposes only is-one and is-zero flags.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_is_one,
  output logic         o_is_zero
);

  logic [W-1:0] r_count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_is_one  = (r_count == W'(1));
  assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/seq_10110_tx.sv
// Serial transmitter: sends PATTERN MSB first, rep_count times, with gap idle cycles between frames.
// All outputs are registered from the next-state decode.
module seq_10110_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
  parameter int               CNT_W   = 4,
  parameter int               GAP_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_10110_tx_if.slave bus
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [GAP_W-1:0] r_gap_lat;
  logic [CNT_W-1:0] r_frames;
  logic             r_dout, r_dout_valid, r_busy, r_done;
  logic             w_dout_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;

  logic             w_accept, w_frame_end, w_last;
  logic             w_rep_one, w_rep_zero, w_gap_one, w_gap_zero;
  logic             w_gap_load, w_gap_dec;
  logic [GAP_W-1:0] w_gap_load_val;

  assign w_accept    = (r_state == IDLE) && bus.start && (bus.rep_count != '0);
  assign w_frame_end = (r_state == SHIFT) && (r_idx == '0) && !bus.abort;
  // An exhausted rep counter is treated as the last frame, never wrapped.
  assign w_last      = w_rep_one || w_rep_zero;

  down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (bus.rep_count),
    .i_dec      (w_frame_end),
    .o_is_one   (w_rep_one),
    .o_is_zero  (w_rep_zero)
  );

  // The gap timer holds the latched gap outside GAP, so is-zero means back-to-back frames.
  assign w_gap_load     = w_accept || ((r_state == GAP) && w_gap_one);
  assign w_gap_load_val = w_accept ? bus.gap : r_gap_lat;
  assign w_gap_dec      = (r_state == GAP) && !w_gap_one;

  down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_load_val),
    .i_dec      (w_gap_dec),
    .o_is_one   (w_gap_one),
    .o_is_zero  (w_gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_idx_nxt   = IDX_LAST;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (r_idx != '0) begin
          w_idx_nxt = r_idx - 1'b1;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end else if (w_gap_zero) begin
          w_idx_nxt = IDX_LAST;
        end else begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (w_gap_one) begin
          w_state_nxt = SHIFT;
          w_idx_nxt   = IDX_LAST;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_dout_nxt  = 1'b0;
    if (w_state_nxt == SHIFT) w_dout_nxt = PATTERN[w_idx_nxt];
    w_valid_nxt = (w_state_nxt == SHIFT);
    w_busy_nxt  = (w_state_nxt == SHIFT) || (w_state_nxt == GAP);
    w_done_nxt  = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_gap_lat    <= '0;
      r_frames     <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      if (w_accept) begin
        r_gap_lat <= bus.gap;
        r_frames  <= '0;
      end else if (w_frame_end) begin
        r_frames  <= r_frames + 1'b1;
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.frames_sent = r_frames;

endmodule

// File: tb/tb_seq_10110_tx.sv
// Self-checking bench for seq_10110_tx: table-driven bursts, hand-written corner cases,
// and random bursts compared against a cycle-indexed arithmetic model of the burst.
module tb_seq_10110_tx;

  localparam int PAT_W = 5;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  typedef struct packed {
    logic             dout;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames;
  } obs_t;

  typedef struct {
    int rep;
    int gp;
    int abort_at;   // burst cycle during which abort is high, -1 for none
    int poke_at;    // burst cycle during which a stray start is pulsed, -1 for none
    int exp_busy;   // hand-derived number of busy cycles
    int exp_frames; // hand-derived final frames_sent
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [PAT_W-1:0] tb_pat = 5'b10110;

  int n_checks = 0;
  int n_fail   = 0;

  seq_10110_tx_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_10110_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o.dout   = bus.dout;
    o.valid  = bus.dout_valid;
    o.busy   = bus.busy;
    o.done   = bus.done;
    o.frames = bus.frames_sent;
    return o;
  endfunction

  // Expected outputs c cycles after the accepting edge, from the burst layout:
  // frame f occupies cycles f*(PAT_W+gap) .. +PAT_W-1, DONE sits at the burst length.
  function automatic obs_t model(input int rep, input int gp, input int a, input int c);
    obs_t o;
    int   per;
    int   total;
    int   fr;
    int   e;
    int   off;
    bit   ab;
    o     = '0;
    per   = PAT_W + gp;
    total = rep * PAT_W + (rep - 1) * gp;
    ab    = (a >= 0) && (a < total);
    fr    = 0;
    for (int f = 0; f < rep; f++) begin
      e = f * per + PAT_W - 1;
      if ((e < c) && !(ab && (e >= a))) fr++;
    end
    o.frames = CNT_W'(fr);
    if (ab && (c > a)) return o;
    if (c < total) begin
      off    = c % per;
      o.busy = 1'b1;
      if (off < PAT_W) begin
        o.valid = 1'b1;
        o.dout  = tb_pat[PAT_W - 1 - off];
      end
    end else if (c == total) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Called at a negedge; start is accepted at the next posedge.
  task automatic run_burst(input int rep, input int gp, input int abort_at, input int poke_at,
                           input string tag, output int busy_cnt, output int frames_final);
    int   total;
    obs_t act;
    total         = rep * PAT_W + (rep - 1) * gp;
    busy_cnt      = 0;
    bus.start     = 1'b1;
    bus.rep_count = CNT_W'(rep);
    bus.gap       = GAP_W'(gp);
    bus.abort     = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= total + 2; c++) begin
      act = get_obs();
      check($sformatf("%s cyc%0d", tag, c), 32'(act), 32'(model(rep, gp, abort_at, c)));
      if (act.busy) busy_cnt++;
      bus.abort = (c == abort_at);
      if (c == poke_at) begin
        bus.start     = 1'b1;
        bus.rep_count = 4'd7;
        bus.gap       = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    frames_final = int'(bus.frames_sent);
  endtask

  vec_t vecs[9];
  int   bc, fr;
  obs_t o;
  int   rep, gp, ab, pk, total;

  initial begin
    vecs[0] = '{rep: 1,  gp: 0,  abort_at: -1, poke_at: -1, exp_busy: 5,  exp_frames: 1};
    vecs[1] = '{rep: 3,  gp: 0,  abort_at: -1, poke_at: 7,  exp_busy: 15, exp_frames: 3};
    vecs[2] = '{rep: 2,  gp: 3,  abort_at: -1, poke_at: 13, exp_busy: 13, exp_frames: 2};
    vecs[3] = '{rep: 4,  gp: 2,  abort_at: 9,  poke_at: -1, exp_busy: 10, exp_frames: 1};
    vecs[4] = '{rep: 2,  gp: 0,  abort_at: 4,  poke_at: -1, exp_busy: 5,  exp_frames: 0};
    vecs[5] = '{rep: 1,  gp: 5,  abort_at: 5,  poke_at: -1, exp_busy: 5,  exp_frames: 1};
    vecs[6] = '{rep: 15, gp: 1,  abort_at: -1, poke_at: -1, exp_busy: 89, exp_frames: 15};
    vecs[7] = '{rep: 3,  gp: 15, abort_at: 25, poke_at: -1, exp_busy: 26, exp_frames: 2};
    vecs[8] = '{rep: 2,  gp: 1,  abort_at: 0,  poke_at: -1, exp_busy: 1,  exp_frames: 0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.rep_count = '0;
    bus.gap       = '0;
    bus.abort     = 1'b0;
    #12;
    check("reset outputs", 32'(get_obs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_burst(vecs[i].rep, vecs[i].gp, vecs[i].abort_at, vecs[i].poke_at,
                $sformatf("vec%0d", i), bc, fr);
      check($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d frames_sent", i), 32'(fr), 32'(vecs[i].exp_frames));
    end

    // Null start: rep_count=0 must leave the transmitter idle and frames_sent untouched.
    bus.start     = 1'b1;
    bus.rep_count = '0;
    bus.gap       = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      o = '0;
      o.frames = CNT_W'(vecs[8].exp_frames);
      check($sformatf("null start cyc%0d", c), 32'(get_obs()), 32'(o));
      @(negedge clk);
    end

    // Asynchronous reset mid-frame, then a clean frame on the first edge after release.
    bus.start     = 1'b1;
    bus.rep_count = 4'd2;
    bus.gap       = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset dout_valid", 32'(bus.dout_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset outputs", 32'(get_obs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(1, 0, -1, -1, "post-reset", bc, fr);
    check("post-reset frames_sent", 32'(fr), 32'd1);

    for (int i = 0; i < 25; i++) begin
      rep   = $urandom_range(1, 15);
      gp    = $urandom_range(0, 15);
      total = rep * PAT_W + (rep - 1) * gp;
      ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, total) : -1;
      pk    = ((ab < 0) && ($urandom_range(0, 1) == 1)) ? $urandom_range(0, total) : -1;
      run_burst(rep, gp, ab, pk, $sformatf("rnd%0d r%0d g%0d a%0d", i, rep, gp, ab), bc, fr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
